// File: rtl/cla_sub_serial.sv
// cla_sub_serial: nibble-serial subtractor, d = x - y - bIn, LSB nibble first.
// Each nibble goes through a 4-bit borrow-lookahead slice (x + ~y + ~b, borrow = ~carry)
// and the borrow is registered between nibbles. A start/busy/done handshake frames
// each operation; latency from the accept edge to done is WIDTH/4 cycles.
// Optional feature: define SUB_OVF_EN to add the signed-overflow output ovf.
module cla_sub_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bOut
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N    = WIDTH / 4;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e state_q, state_d;

  // Operand latches, running borrow and nibble index
  logic [WIDTH-1:0] xr_q, xr_d;
  logic [WIDTH-1:0] yr_q, yr_d;
  logic             b_q, b_d;
  logic [IdxW-1:0]  idx_q, idx_d;

  // Result registers; they hold until the next accepted start
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             busy_q, done_q;

`ifdef SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Slice signals for the nibble currently selected by idx
  logic [IdxW+1:0]  base;
  logic [3:0]       sl_a, sl_c, sl_g, sl_p, sl_sum;
  logic [4:0]       cy;
  logic             last_nib;

  assign base     = {idx_q, 2'b00};
  assign last_nib = (idx_q == IdxW'(N - 1));

  // Select the current nibble: minuend as-is, subtrahend inverted, carry-in = ~borrow
  always_comb begin
    sl_a = xr_q[base +: 4];
    sl_c = ~yr_q[base +: 4];
    sl_g = sl_a & sl_c;
    sl_p = sl_a ^ sl_c;
  end

  // Two-level lookahead carries; every carry is a flat sum of products, no ripple
  always_comb begin
    cy[0] = ~b_q;
    cy[1] = sl_g[0]
          | (sl_p[0] & cy[0]);
    cy[2] = sl_g[1]
          | (sl_p[1] & sl_g[0])
          | (sl_p[1] & sl_p[0] & cy[0]);
    cy[3] = sl_g[2]
          | (sl_p[2] & sl_g[1])
          | (sl_p[2] & sl_p[1] & sl_g[0])
          | (sl_p[2] & sl_p[1] & sl_p[0] & cy[0]);
    cy[4] = sl_g[3]
          | (sl_p[3] & sl_g[2])
          | (sl_p[3] & sl_p[2] & sl_g[1])
          | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
          | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & cy[0]);
    sl_sum = sl_p ^ cy[3:0];
  end

  // Next-state and datapath update for the IDLE -> RUN -> DONE sequence
  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    b_d     = b_q;
    idx_d   = idx_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xr_d    = x;
          yr_d    = y;
          b_d     = bIn;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        d_d[base +: 4] = sl_sum;
        b_d            = ~cy[4];
        idx_d          = idx_q + IdxW'(1);
        if (last_nib) begin
          state_d = StDone;
          bout_d  = ~cy[4];
`ifdef SUB_OVF_EN
          // sl_sum[3] is the result MSB being written on this same edge
          ovf_d   = (xr_q[WIDTH-1] ^ yr_q[WIDTH-1]) & (xr_q[WIDTH-1] ^ sl_sum[3]);
`endif
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      xr_q    <= '0;
      yr_q    <= '0;
      b_q     <= 1'b0;
      idx_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      // Flag registers mirror the state register so outputs come straight from flops
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
`ifdef SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bOut = bout_q;
`ifdef SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_cla_sub_serial.sv
// Bench for cla_sub_serial (WIDTH=16): directed operations with hand-computed results,
// a transaction-level reference model checked every cycle, plus restart and reset cases.
module tb_cla_sub_serial;

  localparam int unsigned W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bIn;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bOut;
`ifdef SUB_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  cla_sub_serial #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .y    (y),
    .bIn  (bIn),
    .busy (busy),
    .done (done),
    .d    (d),
    .bOut (bOut)
`ifdef SUB_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: an operation is accepted when idle; busy for N cycles after the
  // accept edge, done in the next cycle, idle again one cycle later.
  logic         m_active = 1'b0;
  int           m_k = 0;
  logic [W-1:0] m_d = '0;
  logic         m_b = 1'b0;
  logic         m_o = 1'b0;
  logic [W-1:0] in_diff;
  logic         exp_busy, exp_done;

  assign in_diff  = x - y - {{(W-1){1'b0}}, bIn};
  assign exp_busy = m_active && (m_k < N);
  assign exp_done = m_active && (m_k == N);

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_d      <= '0;
      m_b      <= 1'b0;
      m_o      <= 1'b0;
    end else if (m_active) begin
      m_k <= m_k + 1;
      if (m_k >= N) m_active <= 1'b0;
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_d      <= in_diff;
      m_b      <= ({1'b0, x} < ({1'b0, y} + {{W{1'b0}}, bIn}));
      m_o      <= (x[W-1] ^ y[W-1]) & (x[W-1] ^ in_diff[W-1]);
    end
  end

  // Every-cycle comparison against the model; d/bOut are meaningful whenever not busy
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("cyc_done", {31'd0, done}, {31'd0, exp_done});
      if (!exp_busy) begin
        chk("cyc_d", {16'd0, d}, {16'd0, m_d});
        chk("cyc_bOut", {31'd0, bOut}, {31'd0, m_b});
`ifdef SUB_OVF_EN
        chk("cyc_ovf", {31'd0, ovf}, {31'd0, m_o});
`endif
      end
    end
  end

  // One operation from the earliest legal start; inputs scrambled after the accept edge
  task automatic run_op(input logic [W-1:0] tx, input logic [W-1:0] ty, input logic tb,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int   lat;
    logic seen;
    x = tx; y = ty; bIn = tb; start = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        start = 1'b0; x = ~tx; y = tx; bIn = ~tb;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("latency", lat - 1, N);
    chk("lit_d", {16'd0, d}, {16'd0, ed});
    chk("lit_bOut", {31'd0, bOut}, {31'd0, eb});
    chk("model_d", {16'd0, m_d}, {16'd0, ed});
    chk("model_bOut", {31'd0, m_b}, {31'd0, eb});
`ifdef SUB_OVF_EN
    chk("lit_ovf", {31'd0, ovf}, {31'd0, eo});
    chk("model_ovf", {31'd0, m_o}, {31'd0, eo});
`else
    if (eo) begin end
`endif
    @(negedge clk);
  endtask

  initial begin
    int nb, nd;
    rst = 1'b1; start = 1'b0; x = '0; y = '0; bIn = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d", {16'd0, d}, 32'd0);
    chk("rst_bOut", {31'd0, bOut}, 32'd0);
`ifdef SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    run_op(16'h1000, 16'h0000, 1'b1, 16'h0FFF, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    run_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Second start mid-run must be ignored and must not queue
    x = 16'h1234; y = 16'h0234; bIn = 1'b0; start = 1'b1;
    nb = 0; nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 1) begin
        start = 1'b1; x = 16'hFFFF; y = 16'h0001; bIn = 1'b1;
      end
      if (i == 2) start = 1'b0;
      nb += int'(busy === 1'b1);
      nd += int'(done === 1'b1);
    end
    chk("restart_busy_cycles", nb, N);
    chk("restart_done_count", nd, 1);
    chk("restart_d", {16'd0, d}, 32'h1000);
    chk("restart_bOut", {31'd0, bOut}, 32'd0);

    // Reset in the middle of a run clears everything, then a fresh op works
    x = 16'hABCD; y = 16'h1111; bIn = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_d", {16'd0, d}, 32'd0);
    chk("abort_bOut", {31'd0, bOut}, 32'd0);
`ifdef SUB_OVF_EN
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
